merge_tiles: RTL and testbench

MERGE_TILES -- requirements
Module: merge_tiles

---
 rtl/cnn_pkg.sv | 17 +
 rtl/merge_tiles_ctrl.sv | 99 +++++++++
 rtl/merge_tiles.sv | 79 +++++++
 tb/tb_merge_tiles.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the tile-merging datapath.
package cnn_pkg;

    // Two-state merge FSM: gather tiles, then present the finished image.
    typedef enum logic [0:0] {
        StCollect = 1'b0,
        StDone    = 1'b1
    } merge_state_e;

    localparam int unsigned DATA_W_DEFAULT = 32;

    // Width of a tile index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/merge_tiles_ctrl.sv
// Merge control: COLLECT/DONE FSM plus the tile counter, or, when
// MERGE_TILES_IDX_EN is defined, an explicit-index path with a received-tile bitmap.
module merge_tiles_ctrl
    import cnn_pkg::*;
#(
    parameter int unsigned NT    = 9,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tile_valid,
    output logic             tile_ready,
    output logic             img_valid,
    input  logic             img_ready,
`ifdef MERGE_TILES_IDX_EN
    input  logic [IDX_W-1:0] tile_idx,
`endif
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_idx
);

    merge_state_e state_q, state_d;
`ifdef MERGE_TILES_IDX_EN
    logic [NT-1:0] bitmap_q, bitmap_d;
`else
    logic [IDX_W-1:0] count_q, count_d;
`endif

    // Next-state, write strobe and handshake outputs.
    always_comb begin
        state_d    = state_q;
        wr_en      = 1'b0;
        wr_idx     = '0;
        tile_ready = 1'b0;
        img_valid  = 1'b0;
`ifdef MERGE_TILES_IDX_EN
        bitmap_d   = bitmap_q;
`else
        count_d    = count_q;
`endif
        unique case (state_q)
            StCollect: begin
                tile_ready = 1'b1;
`ifdef MERGE_TILES_IDX_EN
                wr_idx = tile_idx;
                if (tile_valid) begin
                    // Out-of-range indices are consumed but neither stored nor counted.
                    if (32'(tile_idx) < NT) begin
                        wr_en = 1'b1;
                        for (int i = 0; i < int'(NT); i++) begin
                            if (32'(tile_idx) == 32'(i)) bitmap_d[i] = 1'b1;
                        end
                    end
                    if (&bitmap_d) state_d = StDone;
                end
`else
                wr_idx = count_q;
                if (tile_valid) begin
                    wr_en = 1'b1;
                    if (32'(count_q) == NT - 1) state_d = StDone;
                    else                        count_d = count_q + IDX_W'(1);
                end
`endif
            end
            StDone: begin
                img_valid = 1'b1;
                if (img_ready) begin
                    state_d = StCollect;
`ifdef MERGE_TILES_IDX_EN
                    bitmap_d = '0;
`else
                    count_d  = '0;
`endif
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StCollect;
`ifdef MERGE_TILES_IDX_EN
            bitmap_q <= '0;
`else
            count_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
`ifdef MERGE_TILES_IDX_EN
            bitmap_q <= bitmap_d;
`else
            count_q  <= count_d;
`endif
        end
    end

endmodule

// File: rtl/merge_tiles.sv
// Reassembles FILTER_SIZE x FILTER_SIZE tiles into a SIZE x SIZE image in raster
// tile order. Optional MERGE_TILES_IDX_EN adds an explicit tile_idx input.
module merge_tiles
    import cnn_pkg::*;
#(
    parameter int unsigned SIZE        = 9,
    parameter int unsigned FILTER_SIZE = 3,
    parameter int unsigned DATA_W      = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tile_valid,
    output logic              tile_ready,
    input  logic [DATA_W-1:0] tile_data [FILTER_SIZE][FILTER_SIZE],
`ifdef MERGE_TILES_IDX_EN
    input  logic [idx_width((SIZE/FILTER_SIZE)*(SIZE/FILTER_SIZE))-1:0] tile_idx,
`endif
    output logic              img_valid,
    input  logic              img_ready,
    output logic [DATA_W-1:0] img [SIZE][SIZE]
);

    localparam int unsigned OUT   = SIZE / FILTER_SIZE;
    localparam int unsigned NT    = OUT * OUT;
    localparam int unsigned IDX_W = idx_width(NT);

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    int unsigned      tile_row;
    int unsigned      tile_col;

    merge_tiles_ctrl #(
        .NT    (NT),
        .IDX_W (IDX_W)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .img_valid  (img_valid),
        .img_ready  (img_ready),
`ifdef MERGE_TILES_IDX_EN
        .tile_idx   (tile_idx),
`endif
        .wr_en      (wr_en),
        .wr_idx     (wr_idx)
    );

    // Tile grid coordinates of the tile being written.
    always_comb begin
        tile_row = 32'(wr_idx) / OUT;
        tile_col = 32'(wr_idx) % OUT;
    end

    // Image store: cleared on reset, otherwise only the addressed tile is overwritten,
    // so words beyond OUT*FILTER_SIZE stay at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(SIZE); r++) begin
                for (int c = 0; c < int'(SIZE); c++) begin
                    img[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int tr = 0; tr < int'(OUT); tr++) begin
                for (int tc = 0; tc < int'(OUT); tc++) begin
                    if (tile_row == 32'(tr) && tile_col == 32'(tc)) begin
                        for (int j = 0; j < int'(FILTER_SIZE); j++) begin
                            for (int k = 0; k < int'(FILTER_SIZE); k++) begin
                                img[tr*FILTER_SIZE+j][tc*FILTER_SIZE+k] <= tile_data[j][k];
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_merge_tiles.sv
// Directed bench for merge_tiles: a default 9x9/3x3 instance and a 10x10/3x3 instance.
// The explicit-index scenario runs only when MERGE_TILES_IDX_EN is defined.
module tb_merge_tiles;

    localparam int unsigned F = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        tv, tr, iv, ir;
    logic [31:0] td [F][F];
    logic [31:0] img [9][9];
    logic [3:0]  tidx;

    logic        tv10, tr10, iv10, ir10;
    logic [31:0] td10 [F][F];
    logic [31:0] img10 [10][10];
    logic [3:0]  tidx10;

    int checks = 0;
    int passed = 0;

    merge_tiles u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tile_valid (tv),
        .tile_ready (tr),
        .tile_data  (td),
`ifdef MERGE_TILES_IDX_EN
        .tile_idx   (tidx),
`endif
        .img_valid  (iv),
        .img_ready  (ir),
        .img        (img)
    );

    merge_tiles #(
        .SIZE        (10),
        .FILTER_SIZE (3),
        .DATA_W      (32)
    ) u_dut10 (
        .clk        (clk),
        .rst_n      (rst_n),
        .tile_valid (tv10),
        .tile_ready (tr10),
        .tile_data  (td10),
`ifdef MERGE_TILES_IDX_EN
        .tile_idx   (tidx10),
`endif
        .img_valid  (iv10),
        .img_ready  (ir10),
        .img        (img10)
    );

    function automatic logic [31:0] pat(input int off, input int t, input int j, input int k);
        return 32'(off + 100 * t + 3 * j + k);
    endfunction

    // Raster-order model: word (r,c) belongs to tile (r/3)*3 + c/3.
    function automatic logic [31:0] exp_word(input int off, input int r, input int c);
        return pat(off, (r / 3) * 3 + c / 3, r % 3, c % 3);
    endfunction

    // Present one patterned tile for exactly one clock edge; valid stays high afterwards.
    task automatic push(input int off, input int t);
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 3; k++)
                td[j][k] = pat(off, t, j, k);
        tidx = 4'(t);
        tv   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic release_img();
        tv = 1'b0;
        ir = 1'b1;
        @(posedge clk);
        #1;
        ir = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        tv = 1'b0; ir = 1'b0; tidx = '0;
        tv10 = 1'b0; ir10 = 1'b0; tidx10 = '0;
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 3; k++) begin
                td[j][k] = '0;
                td10[j][k] = '0;
            end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (tr !== 1'b1) $display("FAIL reset_tile_ready got=%b exp=1", tr); else passed++;
        checks++; if (iv !== 1'b0) $display("FAIL reset_img_valid got=%b exp=0", iv); else passed++;
        bad = 0;
        for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++) if (img[r][c] !== 32'd0) bad++;
        checks++; if (bad != 0) $display("FAIL reset_img_zero nonzero_words=%0d exp=0", bad);
        else passed++;
        checks++; if (tr10 !== 1'b1) $display("FAIL reset10_tile_ready got=%b exp=1", tr10);
        else passed++;
        checks++; if (iv10 !== 1'b0) $display("FAIL reset10_img_valid got=%b exp=0", iv10);
        else passed++;
        bad = 0;
        for (int r = 0; r < 10; r++) for (int c = 0; c < 10; c++) if (img10[r][c] !== 32'd0) bad++;
        checks++; if (bad != 0) $display("FAIL reset10_img_zero nonzero_words=%0d exp=0", bad);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_raster_frame();
        int bad;
        for (int t = 0; t < 9; t++) begin
            push(0, t);
            if (t == 7) begin
                checks++;
                if (iv !== 1'b0) $display("FAIL raster_valid_early got=%b exp=0", iv);
                else passed++;
            end
        end
        tv = 1'b0;
        checks++; if (iv !== 1'b1) $display("FAIL raster_img_valid got=%b exp=1", iv); else passed++;
        checks++; if (tr !== 1'b0) $display("FAIL raster_tile_ready got=%b exp=0", tr); else passed++;
        checks++; if (img[4][7] !== 32'd504) $display("FAIL raster_img_4_7 got=%0d exp=504", img[4][7]);
        else passed++;
        checks++; if (img[4][4] !== 32'd404) $display("FAIL raster_img_4_4 got=%0d exp=404", img[4][4]);
        else passed++;
        bad = 0;
        for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++)
            if (img[r][c] !== exp_word(0, r, c)) bad++;
        checks++; if (bad != 0) $display("FAIL raster_full_image bad_words=%0d exp=0", bad);
        else passed++;
    endtask

    task automatic test_hold_done();
        int bad;
        for (int j = 0; j < 3; j++) for (int k = 0; k < 3; k++) td[j][k] = 32'hDEAD_BEEF;
        tidx = 4'd0;
        tv = 1'b1;
        ir = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tr !== 1'b0 || iv !== 1'b1)
                $display("FAIL hold_cycle%0d tile_ready=%b img_valid=%b exp 0/1", n, tr, iv);
            else passed++;
        end
        bad = 0;
        for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++)
            if (img[r][c] !== exp_word(0, r, c)) bad++;
        checks++; if (bad != 0) $display("FAIL hold_image_stable bad_words=%0d exp=0", bad);
        else passed++;
        release_img();
        checks++; if (tr !== 1'b1) $display("FAIL release_tile_ready got=%b exp=1", tr); else passed++;
        checks++; if (iv !== 1'b0) $display("FAIL release_img_valid got=%b exp=0", iv); else passed++;
        checks++;
        if (img[8][8] !== 32'd808) $display("FAIL release_no_clear got=%0d exp=808", img[8][8]);
        else passed++;
    endtask

    task automatic test_mid_frame_reset();
        int bad;
        for (int t = 0; t < 4; t++) push(5000, t);
        checks++;
        if (img[2][5] !== 32'd5108) $display("FAIL partial_write got=%0d exp=5108", img[2][5]);
        else passed++;
        // Reset coincides with a valid tile: reset must win.
        for (int j = 0; j < 3; j++) for (int k = 0; k < 3; k++) td[j][k] = pat(5000, 4, j, k);
        tidx  = 4'd4;
        tv    = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tv    = 1'b0;
        bad = 0;
        for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++) if (img[r][c] !== 32'd0) bad++;
        checks++; if (bad != 0) $display("FAIL midreset_img_zero nonzero_words=%0d exp=0", bad);
        else passed++;
        checks++; if (iv !== 1'b0) $display("FAIL midreset_img_valid got=%b exp=0", iv); else passed++;
        checks++; if (tr !== 1'b1) $display("FAIL midreset_tile_ready got=%b exp=1", tr); else passed++;
        for (int t = 0; t < 9; t++) begin
            push(7000, t);
            if (t == 7) begin
                checks++;
                if (iv !== 1'b0) $display("FAIL fresh_valid_early got=%b exp=0", iv);
                else passed++;
            end
        end
        tv = 1'b0;
        checks++; if (iv !== 1'b1) $display("FAIL fresh_img_valid got=%b exp=1", iv); else passed++;
        bad = 0;
        for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++)
            if (img[r][c] !== exp_word(7000, r, c)) bad++;
        checks++; if (bad != 0) $display("FAIL fresh_full_image bad_words=%0d exp=0", bad);
        else passed++;
        release_img();
    endtask

    task automatic test_size10();
        int bad_in;
        int bad_edge;
        for (int j = 0; j < 3; j++) for (int k = 0; k < 3; k++) td10[j][k] = 32'hFFFF_FFFF;
        tv10 = 1'b1;
        for (int t = 0; t < 9; t++) begin
            tidx10 = 4'(t);
            @(posedge clk);
            #1;
        end
        tv10 = 1'b0;
        checks++; if (iv10 !== 1'b1) $display("FAIL size10_img_valid got=%b exp=1", iv10);
        else passed++;
        bad_in = 0;
        bad_edge = 0;
        for (int r = 0; r < 10; r++) for (int c = 0; c < 10; c++) begin
            if (r < 9 && c < 9) begin
                if (img10[r][c] !== 32'hFFFF_FFFF) bad_in++;
            end else if (img10[r][c] !== 32'd0) bad_edge++;
        end
        checks++; if (bad_in != 0) $display("FAIL size10_covered bad_words=%0d exp=0", bad_in);
        else passed++;
        checks++; if (bad_edge != 0) $display("FAIL size10_row9_col9 nonzero=%0d exp=0", bad_edge);
        else passed++;
        ir10 = 1'b1;
        @(posedge clk);
        #1;
        ir10 = 1'b0;
        checks++; if (tr10 !== 1'b1) $display("FAIL size10_release got=%b exp=1", tr10);
        else passed++;
    endtask

`ifdef MERGE_TILES_IDX_EN
    task automatic test_idx();
        int seq [11];
        int bad;
        seq = '{8, 7, 6, 5, 4, 4, 9, 3, 2, 1, 0};
        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < 3; j++) for (int k = 0; k < 3; k++)
                td[j][k] = (i == 5) ? 32'h0000_00AA : pat(9000, seq[i], j, k);
            tidx = 4'(seq[i]);
            tv   = 1'b1;
            @(posedge clk);
            #1;
            if (i == 9) begin
                checks++;
                if (iv !== 1'b0) $display("FAIL idx_valid_early got=%b exp=0", iv);
                else passed++;
            end
        end
        tv = 1'b0;
        checks++; if (iv !== 1'b1) $display("FAIL idx_img_valid got=%b exp=1", iv); else passed++;
        bad = 0;
        for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++) begin
            if (r / 3 == 1 && c / 3 == 1) begin
                if (img[r][c] !== 32'h0000_00AA) bad++;
            end else if (img[r][c] !== exp_word(9000, r, c)) bad++;
        end
        checks++; if (bad != 0) $display("FAIL idx_full_image bad_words=%0d exp=0", bad);
        else passed++;
        release_img();
        checks++; if (tr !== 1'b1) $display("FAIL idx_release got=%b exp=1", tr); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_raster_frame();
        test_hold_done();
        test_mid_frame_reset();
        test_size10();
`ifdef MERGE_TILES_IDX_EN
        test_idx();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
